// File: rtl/event_led_blinker.sv
// Stretches single-cycle event pulses into fixed-length LED blinks, replaying queued events back to back.
// LED lights one edge after a startable event; excess events beyond MAX_PENDING are dropped and flagged sticky.
module event_led_blinker #(
  parameter int ON_CYCLES      = 2700000,
  parameter int OFF_CYCLES     = 2700000,
  parameter int MAX_PENDING    = 7,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 event_in,
  input  logic                                 ovf_clr,
  output logic                                 led_o,
  output logic                                 busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending,
  output logic                                 overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic              LED_ON   = (LED_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic              LED_OFF  = ~LED_ON;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              start;
  logic              drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= LED_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    start   = ((state_q == S_IDLE) || ((state_q == S_OFF) && (cnt_q == '0)))
              && ((pend_q != '0) || event_in);
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ON;
          cnt_d   = ON_LOAD;
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          state_d = S_OFF;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OFF: begin
        if (cnt_q == '0) begin
          state_d = start ? S_ON : S_IDLE;
          cnt_d   = start ? ON_LOAD : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // An event coinciding with a start cancels out: it is either consumed directly or replaces the one dequeued.
    drop   = event_in && !start && (pend_q == PEND_MAX);
    pend_d = pend_q;
    if (event_in && !start && !drop) begin
      pend_d = pend_q + 1'b1;
    end else if (!event_in && start) begin
      pend_d = pend_q - 1'b1;
    end

    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    led_d  = (state_d == S_ON) ? LED_ON : LED_OFF;
    busy_d = (state_d != S_IDLE);
  end

  assign led_o    = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_event_led_blinker.sv
// Scenario bench for event_led_blinker with short blink timings; expectations derived from blink start edges.
module tb_event_led_blinker;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int MAXP  = 2;

  logic       clk;
  logic       rst_n;
  logic       event_in;
  logic       ovf_clr;
  logic       led_o;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  event_led_blinker #(
    .ON_CYCLES(ON_C),
    .OFF_CYCLES(OFF_C),
    .MAX_PENDING(MAXP),
    .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .event_in(event_in),
    .ovf_clr(ovf_clr),
    .led_o(led_o),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } obs_t;

  int   tests_run = 0;
  int   tests_failed = 0;
  obs_t exp_q[$];

  // Scenario description: edges (relative to first event) of inputs, blink starts, accepted events.
  int ev_e[$];
  int clr_e[$];
  int st_e[$];
  int acc_e[$];
  int ovf_set_e;
  int ovf_clr_e;

  function automatic bit has(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_le(input int q[$], input int t);
    int n = 0;
    foreach (q[i]) if (q[i] <= t) n++;
    return n;
  endfunction

  // Expected outputs just after edge t.
  function automatic obs_t model(input int t);
    obs_t o;
    logic lit = 1'b0;
    logic bsy = 1'b0;
    foreach (st_e[i]) begin
      if (t >= st_e[i] && t < st_e[i] + ON_C) lit = 1'b1;
      if (t >= st_e[i] && t < st_e[i] + ON_C + OFF_C) bsy = 1'b1;
    end
    o.led  = ~lit;
    o.busy = bsy;
    o.pend = 2'(count_le(acc_e, t) - count_le(st_e, t));
    o.ovf  = (ovf_set_e >= 0) && (t >= ovf_set_e) && ((ovf_clr_e < 0) || (t < ovf_clr_e));
    return o;
  endfunction

  function automatic void clear_scn();
    ev_e.delete(); clr_e.delete(); st_e.delete(); acc_e.delete();
    ovf_set_e = -1;
    ovf_clr_e = -1;
  endfunction

  // Drives inputs for edge t, records its expectation, and returns 1 time unit after that edge.
  task automatic step_edge(input int t);
    event_in = has(ev_e, t);
    ovf_clr  = has(clr_e, t);
    exp_q.push_back(model(t));
    @(posedge clk);
    #1;
    event_in = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b1; event_in = 1'b0; ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    got = {led_o, busy, pending, overflow};
    tests_run++;
    if (got !== obs_t'(5'b10000)) begin
      tests_failed++;
      $display("FAIL reset_async got=%b exp=%b", got, 5'b10000);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    got = {led_o, busy, pending, overflow};
    tests_run++;
    if (got !== obs_t'(5'b10000)) begin
      tests_failed++;
      $display("FAIL reset_release got=%b exp=%b", got, 5'b10000);
    end
  endtask

  task automatic test_single();
    obs_t got, e;
    clear_scn();
    ev_e = '{0}; st_e = '{0}; acc_e = '{0};
    for (int t = 0; t < 10; t++) begin
      step_edge(t);
      e = exp_q.pop_front();
      got = {led_o, busy, pending, overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL single edge=%0d got=%b exp=%b (led,busy,pend,ovf)", t, got, e);
      end
    end
  endtask

  task automatic test_queued();
    obs_t got, e;
    clear_scn();
    ev_e = '{0, 1, 2}; st_e = '{0, 7, 14}; acc_e = '{0, 1, 2};
    for (int t = 0; t < 22; t++) begin
      step_edge(t);
      e = exp_q.pop_front();
      got = {led_o, busy, pending, overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL queued edge=%0d got=%b exp=%b (led,busy,pend,ovf)", t, got, e);
      end
    end
  endtask

  task automatic test_overflow_clear();
    obs_t got, e;
    clear_scn();
    ev_e = '{0, 1, 2, 3}; st_e = '{0, 7, 14}; acc_e = '{0, 1, 2};
    clr_e = '{30}; ovf_set_e = 3; ovf_clr_e = 30;
    for (int t = 0; t < 33; t++) begin
      step_edge(t);
      e = exp_q.pop_front();
      got = {led_o, busy, pending, overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL overflow_clear edge=%0d got=%b exp=%b (led,busy,pend,ovf)", t, got, e);
      end
    end
  endtask

  task automatic test_set_beats_clear();
    obs_t got, e;
    clear_scn();
    ev_e = '{0, 1, 2, 3}; st_e = '{0, 7, 14}; acc_e = '{0, 1, 2};
    clr_e = '{3, 25}; ovf_set_e = 3; ovf_clr_e = 25;
    for (int t = 0; t < 27; t++) begin
      step_edge(t);
      e = exp_q.pop_front();
      got = {led_o, busy, pending, overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL set_beats_clear edge=%0d got=%b exp=%b (led,busy,pend,ovf)", t, got, e);
      end
    end
  endtask

  task automatic test_events_during_off();
    obs_t got, e;
    for (int pass = 0; pass < 2; pass++) begin
      clear_scn();
      st_e = '{0, 7};
      if (pass == 0) begin
        ev_e = '{0, 5}; acc_e = '{0, 5};
      end else begin
        ev_e = '{0, 7}; acc_e = '{0, 7};
      end
      for (int t = 0; t < 17; t++) begin
        step_edge(t);
        e = exp_q.pop_front();
        got = {led_o, busy, pending, overflow};
        tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL events_off pass=%0d edge=%0d got=%b exp=%b (led,busy,pend,ovf)", pass, t, got, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    obs_t got, e;
    clear_scn();
    ev_e = '{0, 1, 2, 3}; st_e = '{0}; acc_e = '{0, 1, 2}; ovf_set_e = 3;
    for (int t = 0; t < 4; t++) begin
      step_edge(t);
      e = exp_q.pop_front();
      got = {led_o, busy, pending, overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL mid_blink_pre edge=%0d got=%b exp=%b (led,busy,pend,ovf)", t, got, e);
      end
    end
    rst_n = 1'b0;
    #1;
    got = {led_o, busy, pending, overflow};
    tests_run++;
    if (got !== obs_t'(5'b10000)) begin
      tests_failed++;
      $display("FAIL mid_blink_async got=%b exp=%b", got, 5'b10000);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_scn();
    for (int t = 0; t < 12; t++) begin
      step_edge(t);
      e = exp_q.pop_front();
      got = {led_o, busy, pending, overflow};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL mid_blink_post edge=%0d got=%b exp=%b (led,busy,pend,ovf)", t, got, e);
      end
    end
  endtask

  initial begin
    clear_scn();
    test_reset();
    test_single();
    test_queued();
    test_overflow_clear();
    test_set_beats_clear();
    test_events_during_off();
    test_reset_mid_blink();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
